// File: rtl/systolic_ctrl.sv
// Tile sequencer for a systolic array: weight load/latch, skewed input streaming,
// drain and result write-back, with global buffer addressing.
module systolic_ctrl #(
   parameter int unsigned ADDR_WIDTH   = 17,
   parameter int unsigned PE_ROW       = 16,
   parameter int unsigned LENGTH       = 16,
   parameter int unsigned DRAIN_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  accumulate,
   input  logic [ADDR_WIDTH-1:0] wgt_base,
   input  logic [ADDR_WIDTH-1:0] in_base,
   input  logic [ADDR_WIDTH-1:0] out_base,
   output logic [ADDR_WIDTH-1:0] raddr_a,
   output logic [ADDR_WIDTH-1:0] raddr_b,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic                  write,
   output logic                  load_weight,
   output logic                  save,
   output logic [PE_ROW-1:0]     enable,
   output logic                  first_partial,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned MAX_CNT = (LENGTH > DRAIN_CYCLES) ? LENGTH : DRAIN_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_W_LOAD, S_W_SAVE, S_GAP, S_STREAM, S_DRAIN, S_WRITE, S_DONE
   } state_t;

   state_t                state, state_d;
   logic [CNT_W-1:0]      cnt, cnt_d;
   logic [ADDR_WIDTH-1:0] wgt_q, in_q, out_q, wgt_d, in_d, out_d;
   logic [ADDR_WIDTH-1:0] raddr_a_d, raddr_b_d, waddr_d;
   logic                  write_d, load_weight_d, save_d, first_partial_d, busy_d, done_d;
   logic [PE_ROW-1:0]     enable_d;
   logic                  last_len;

   assign last_len = (cnt == CNT_W'(LENGTH - 1));

   // Next state, next counter and next registered outputs (computed from the next state)
   always_comb begin
      state_d = state;
      cnt_d   = cnt + CNT_W'(1);
      wgt_d   = wgt_q;
      in_d    = in_q;
      out_d   = out_q;

      case (state)
         S_IDLE: begin
            cnt_d = '0;
            if (start) begin
               wgt_d = wgt_base;
               in_d  = in_base;
               out_d = out_base;
               if (!abort) state_d = S_W_LOAD;
            end
         end
         S_W_LOAD: if (last_len) state_d = S_W_SAVE;
         S_W_SAVE: state_d = S_GAP;
         S_GAP:    state_d = S_STREAM;
         S_STREAM: if (last_len) state_d = S_DRAIN;
         S_DRAIN:  if (cnt == CNT_W'(DRAIN_CYCLES - 1)) state_d = S_WRITE;
         S_WRITE:  if (last_len) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      if (state != S_IDLE && abort) state_d = S_IDLE;
      if (state_d != state) cnt_d = '0;

      raddr_a_d       = raddr_a;
      raddr_b_d       = raddr_b;
      waddr_d         = waddr;
      write_d         = 1'b0;
      load_weight_d   = 1'b0;
      save_d          = 1'b0;
      enable_d        = '0;
      first_partial_d = first_partial;
      busy_d          = 1'b1;
      done_d          = 1'b0;

      case (state_d)
         S_IDLE: begin
            raddr_a_d       = '0;
            raddr_b_d       = '0;
            waddr_d         = '0;
            first_partial_d = 1'b0;
            busy_d          = 1'b0;
         end
         S_W_LOAD: begin
            raddr_a_d     = wgt_d + ADDR_WIDTH'(cnt_d);
            load_weight_d = 1'b1;
            if (state == S_IDLE) first_partial_d = ~accumulate;
         end
         S_W_SAVE: begin
            save_d        = 1'b1;
            load_weight_d = 1'b1;
         end
         S_GAP: ;
         S_STREAM: begin
            raddr_a_d = in_d + ADDR_WIDTH'(cnt_d);
            // Row i turns on once k exceeds i; saturates naturally when LENGTH > PE_ROW
            for (int unsigned i = 0; i < PE_ROW; i++) enable_d[i] = (32'(cnt_d) > i);
         end
         S_DRAIN: enable_d = '1;
         S_WRITE: begin
            write_d   = 1'b1;
            waddr_d   = out_d + ADDR_WIDTH'(cnt_d);
            raddr_b_d = out_d + ADDR_WIDTH'(cnt_d);
            enable_d  = '1;
         end
         S_DONE: done_d = 1'b1;
         default: busy_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= S_IDLE;
         cnt           <= '0;
         wgt_q         <= '0;
         in_q          <= '0;
         out_q         <= '0;
         raddr_a       <= '0;
         raddr_b       <= '0;
         waddr         <= '0;
         write         <= 1'b0;
         load_weight   <= 1'b0;
         save          <= 1'b0;
         enable        <= '0;
         first_partial <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state         <= state_d;
         cnt           <= cnt_d;
         wgt_q         <= wgt_d;
         in_q          <= in_d;
         out_q         <= out_d;
         raddr_a       <= raddr_a_d;
         raddr_b       <= raddr_b_d;
         waddr         <= waddr_d;
         write         <= write_d;
         load_weight   <= load_weight_d;
         save          <= save_d;
         enable        <= enable_d;
         first_partial <= first_partial_d;
         busy          <= busy_d;
         done          <= done_d;
      end
   end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: per-cycle tile trace compared against a
// phase-table reference model, plus abort, reset and start-while-busy scenarios.
module tb_systolic_ctrl;

   localparam int unsigned AW   = 17;
   localparam int unsigned PR   = 16;
   localparam int unsigned L    = 16;
   localparam int unsigned D    = 16;
   localparam int unsigned TILE = L + 1 + 1 + L + D + L + 1;

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic          start = 1'b0, abort = 1'b0, accumulate = 1'b0;
   logic [AW-1:0] wgt_base = '0, in_base = '0, out_base = '0;
   logic [AW-1:0] raddr_a, raddr_b, waddr;
   logic          write, load_weight, save, first_partial, busy, done;
   logic [PR-1:0] enable;

   int checks = 0;
   int failures = 0;

   systolic_ctrl #(.ADDR_WIDTH(AW), .PE_ROW(PR), .LENGTH(L), .DRAIN_CYCLES(D)) dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort), .accumulate(accumulate),
      .wgt_base(wgt_base), .in_base(in_base), .out_base(out_base),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .waddr(waddr), .write(write),
      .load_weight(load_weight), .save(save), .enable(enable),
      .first_partial(first_partial), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] ra;
      logic          chk_ra;
      logic [AW-1:0] wa;
      logic          chk_wa;
      logic          wr, lw, sv, fp, bsy, dn;
      logic [PR-1:0] en;
   } exp_t;

   function automatic logic [PR-1:0] en_of(input int k);
      logic [63:0] t;
      if (k >= int'(PR)) return '1;
      t = (64'd1 << k) - 64'd1;
      return PR'(t);
   endfunction

   // Expected outputs c cycles after the start edge, from the phase layout of a tile
   function automatic exp_t model(input int c, input logic [AW-1:0] wb, ib, ob, input logic acc);
      exp_t e;
      int   l = int'(L);
      int   d = int'(D);
      e.ra = '0; e.chk_ra = 1'b0; e.wa = '0; e.chk_wa = 1'b0;
      e.wr = 1'b0; e.lw = 1'b0; e.sv = 1'b0; e.en = '0;
      e.fp = ~acc; e.bsy = 1'b1; e.dn = 1'b0;
      if (c < l) begin
         e.ra = wb + AW'(c); e.chk_ra = 1'b1; e.lw = 1'b1;
      end else if (c == l) begin
         e.ra = wb + AW'(l - 1); e.chk_ra = 1'b1; e.lw = 1'b1; e.sv = 1'b1;
      end else if (c == l + 1) begin
         e.ra = wb + AW'(l - 1); e.chk_ra = 1'b1;
      end else if (c < 2*l + 2) begin
         e.ra = ib + AW'(c - l - 2); e.chk_ra = 1'b1; e.en = en_of(c - l - 2);
      end else if (c < 2*l + 2 + d) begin
         e.ra = ib + AW'(l - 1); e.chk_ra = 1'b1; e.en = '1;
      end else if (c < 3*l + 2 + d) begin
         e.wa = ob + AW'(c - 2*l - 2 - d); e.chk_wa = 1'b1; e.wr = 1'b1; e.en = '1;
      end else begin
         e.dn = 1'b1;
      end
      return e;
   endfunction

   task automatic test_reset();
      rstn = 1'b1;
      #2 rstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({raddr_a, raddr_b, waddr, write, load_weight, save, enable, first_partial, busy, done} !== '0) begin
         failures++;
         $display("FAIL reset_hold busy=%0b enable=%h raddr_a=%h", busy, enable, raddr_a);
      end
      rstn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if ({raddr_a, raddr_b, waddr, write, load_weight, save, enable, first_partial, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_idle cyc=%0d busy=%0b enable=%h raddr_a=%h done=%0b", i, busy, enable, raddr_a, done);
         end
      end
   endtask

   // Runs one full tile and checks every cycle; base inputs are scrambled while busy
   task automatic test_tile(input string name, input logic [AW-1:0] wb, ib, ob,
                            input logic acc, input bit busy_starts);
      exp_t e;
      int   busy_n = 0;
      int   done_n = 0;
      @(negedge clk);
      wgt_base = wb; in_base = ib; out_base = ob; accumulate = acc; start = 1'b1;
      for (int c = 0; c < int'(TILE); c++) begin
         @(negedge clk);
         e = model(c, wb, ib, ob, acc);
         checks++;
         if (busy !== e.bsy || done !== e.dn || load_weight !== e.lw || save !== e.sv ||
             write !== e.wr || enable !== e.en || first_partial !== e.fp) begin
            failures++;
            $display("FAIL %s ctl c=%0d got b%0b d%0b lw%0b sv%0b wr%0b en=%h fp%0b required b%0b d%0b lw%0b sv%0b wr%0b en=%h fp%0b",
                     name, c, busy, done, load_weight, save, write, enable, first_partial,
                     e.bsy, e.dn, e.lw, e.sv, e.wr, e.en, e.fp);
         end
         if (e.chk_ra) begin
            checks++;
            if (raddr_a !== e.ra) begin
               failures++;
               $display("FAIL %s raddr_a c=%0d got=%h required=%h", name, c, raddr_a, e.ra);
            end
         end
         if (e.chk_wa) begin
            checks++;
            if (waddr !== e.wa || raddr_b !== e.wa) begin
               failures++;
               $display("FAIL %s waddr c=%0d got waddr=%h raddr_b=%h required=%h", name, c, waddr, raddr_b, e.wa);
            end
         end
         busy_n += int'(busy);
         done_n += int'(done);
         start      = busy_starts && (c == 9 || c == 39);
         wgt_base   = AW'($urandom);
         in_base    = AW'($urandom);
         out_base   = AW'($urandom);
         accumulate = 1'($urandom);
      end
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         busy_n += int'(busy);
         done_n += int'(done);
         checks++;
         if (busy !== 1'b0 || write !== 1'b0 || enable !== '0 || load_weight !== 1'b0) begin
            failures++;
            $display("FAIL %s post_idle i=%0d busy=%0b write=%0b enable=%h", name, i, busy, write, enable);
         end
      end
      checks++;
      if (busy_n != int'(TILE) || done_n != 1) begin
         failures++;
         $display("FAIL %s window busy_cycles=%0d done_pulses=%0d required %0d and 1", name, busy_n, done_n, TILE);
      end
   endtask

   task automatic test_basic();
      test_tile("basic", AW'(32'h20), AW'(32'h00), AW'(32'h40), 1'b0, 1'b0);
   endtask

   task automatic test_accumulate();
      test_tile("accum", AW'(32'h100), AW'(32'h200), AW'(32'h40), 1'b1, 1'b0);
   endtask

   task automatic test_wrap();
      test_tile("wrap", AW'(32'h1FFF8), AW'(32'h1FFF4), AW'(32'h1FFF8), 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 3; i++)
         test_tile("random", AW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom), 1'b0);
   endtask

   task automatic test_start_while_busy();
      test_tile("start_busy", AW'(32'h500), AW'(32'h600), AW'(32'h700), 1'b0, 1'b1);
   endtask

   task automatic test_start_abort_idle();
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (busy !== 1'b0 || load_weight !== 1'b0) begin
            failures++;
            $display("FAIL start_abort_idle i=%0d busy=%0b load_weight=%0b required 0", i, busy, load_weight);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_abort();
      int done_n = 0;
      int busy_n = 0;
      @(negedge clk);
      wgt_base = AW'(32'h80); in_base = AW'(32'h90); out_base = AW'(32'hA0); start = 1'b1;
      for (int c = 0; c <= int'(L) + 2 + 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      checks++;
      if (busy !== 1'b1 || enable !== 16'h001F || raddr_a !== AW'(32'h95)) begin
         failures++;
         $display("FAIL abort_pre busy=%0b enable=%h raddr_a=%h required 1 001f 00095", busy, enable, raddr_a);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if ({raddr_a, raddr_b, waddr, write, load_weight, save, enable, first_partial, busy, done} !== '0) begin
         failures++;
         $display("FAIL abort_zero busy=%0b enable=%h raddr_a=%h done=%0b", busy, enable, raddr_a, done);
      end
      for (int i = 0; i < int'(TILE); i++) begin
         @(negedge clk);
         done_n += int'(done);
         busy_n += int'(busy);
      end
      checks++;
      if (done_n != 0 || busy_n != 0) begin
         failures++;
         $display("FAIL abort_quiet done_pulses=%0d busy_cycles=%0d required 0", done_n, busy_n);
      end
      test_tile("after_abort", AW'(32'h80), AW'(32'h90), AW'(32'hA0), 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_op();
      @(negedge clk);
      wgt_base = AW'(32'h10); in_base = AW'(32'h30); out_base = AW'(32'h50); start = 1'b1;
      for (int c = 0; c <= 54; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      checks++;
      if (write !== 1'b1 || waddr !== AW'(32'h54)) begin
         failures++;
         $display("FAIL midreset_pre write=%0b waddr=%h required 1 00054", write, waddr);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({raddr_a, raddr_b, waddr, write, load_weight, save, enable, first_partial, busy, done} !== '0) begin
         failures++;
         $display("FAIL midreset_async write=%0b busy=%0b waddr=%h enable=%h", write, busy, waddr, enable);
      end
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || write !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_idle i=%0d busy=%0b write=%0b done=%0b", i, busy, write, done);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_accumulate();
      test_wrap();
      test_random();
      test_start_while_busy();
      test_start_abort_idle();
      test_abort();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
